// File: rtl/cp0_irq_timer.sv
`default_nettype none
// ============================================================================
// Module : cp0_irq_timer
// Brief  : CP0 interrupt unit: synchronised level/edge external lines,
//          N_TMR compare timers with optional auto-reload, unified pending/mask.
// Rev    : 1.0  initial release
// ============================================================================
module cp0_irq_timer #(
  parameter int N_IRQ = 6,
  parameter int N_TMR = 2,
  parameter int CW    = 32
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   WE,
  input  logic [4:0]             IDX,
  input  logic [31:0]            WD,
  output logic [31:0]            RD,
  input  logic                   IEN_WB,
  input  logic                   EXL,
  input  logic [N_IRQ-1:0]       IRQ_IN,
  output logic [N_IRQ+N_TMR-1:0] PENDING,
  output logic                   INTERRUPT
);

  localparam int         NP          = N_IRQ + N_TMR;
  localparam logic [4:0] IDX_STATUS  = 5'd0;
  localparam logic [4:0] IDX_PENDING = 5'd1;
  localparam logic [4:0] IDX_MODE    = 5'd2;
  localparam logic [4:0] IDX_COUNT   = 5'd3;

  logic                  ie_q;
  logic [NP-1:0]         mask_q;
  logic [N_IRQ-1:0]      mode_q;
  logic [N_IRQ-1:0]      sync1_q, sync2_q, sync3_q;
  logic [N_IRQ-1:0]      sticky_q, sticky_d;
  logic [CW-1:0]         count_q, count_d;

  logic [N_TMR*CW-1:0]   cmp_all;
  logic [N_TMR*CW-1:0]   per_all;
  logic [N_TMR*2-1:0]    ctrl_all;
  logic [N_TMR-1:0]      tpend;
  logic [NP-1:0]         pend;

  logic                  wr_status, wr_pend, wr_mode, wr_count;
  logic [NP-1:0]         w1c;
  logic                  unused_wd;

  assign wr_status = WE && (IDX == IDX_STATUS);
  assign wr_pend   = WE && (IDX == IDX_PENDING);
  assign wr_mode   = WE && (IDX == IDX_MODE);
  assign wr_count  = WE && (IDX == IDX_COUNT);
  assign w1c       = wr_pend ? WD[NP-1:0] : '0;
  assign unused_wd = ^WD;

  // Edge-mode lines latch a synced rising edge; leaving edge mode drops the latch.
  always_comb begin
    sticky_d = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (!mode_q[i])
        sticky_d[i] = 1'b0;
      else if (sync2_q[i] && !sync3_q[i])
        sticky_d[i] = 1'b1;
      else if (w1c[i])
        sticky_d[i] = 1'b0;
      else
        sticky_d[i] = sticky_q[i];
    end
  end

  always_comb begin
    count_d = count_q + CW'(1);
    if (wr_count)
      count_d = WD[CW-1:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ie_q     <= 1'b0;
      mask_q   <= '0;
      mode_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      sync1_q  <= IRQ_IN;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      sticky_q <= sticky_d;
      count_q  <= count_d;
      if (wr_status) begin
        ie_q   <= WD[0];
        mask_q <= WD[8 +: NP];
      end
      if (wr_mode)
        mode_q <= WD[N_IRQ-1:0];
    end
  end

  for (genvar k = 0; k < N_TMR; k++) begin : g_tmr
    localparam logic [4:0] IDX_CMP  = 5'(4 + 3*k);
    localparam logic [4:0] IDX_PER  = 5'(5 + 3*k);
    localparam logic [4:0] IDX_CTRL = 5'(6 + 3*k);

    logic [CW-1:0] cmp_q, cmp_d;
    logic [CW-1:0] per_q, per_d;
    logic          en_q, en_d;
    logic          prd_q, prd_d;
    logic          pend_q, pend_d;
    logic          match, wr_cmp, wr_per, wr_ctrl, clr;

    assign wr_cmp  = WE && (IDX == IDX_CMP);
    assign wr_per  = WE && (IDX == IDX_PER);
    assign wr_ctrl = WE && (IDX == IDX_CTRL);
    assign match   = en_q && (count_q == cmp_q);
    assign clr     = wr_cmp || w1c[N_IRQ+k];

    // Match sets over any same-cycle clear; a CPU compare write beats the reload.
    always_comb begin
      cmp_d  = cmp_q;
      per_d  = per_q;
      en_d   = en_q;
      prd_d  = prd_q;
      pend_d = match || (pend_q && !clr);
      if (wr_cmp)
        cmp_d = WD[CW-1:0];
      else if (match && prd_q)
        cmp_d = cmp_q + per_q;
      if (wr_per)
        per_d = WD[CW-1:0];
      if (wr_ctrl) begin
        en_d  = WD[0];
        prd_d = WD[1];
      end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        cmp_q  <= '0;
        per_q  <= '0;
        en_q   <= 1'b0;
        prd_q  <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cmp_q  <= cmp_d;
        per_q  <= per_d;
        en_q   <= en_d;
        prd_q  <= prd_d;
        pend_q <= pend_d;
      end
    end

    assign cmp_all[k*CW +: CW] = cmp_q;
    assign per_all[k*CW +: CW] = per_q;
    assign ctrl_all[2*k +: 2]  = {prd_q, en_q};
    assign tpend[k]            = pend_q;
  end

  assign pend      = {tpend, (mode_q & sticky_q) | (~mode_q & sync2_q)};
  assign PENDING   = pend;
  assign INTERRUPT = ie_q && !EXL && IEN_WB && (|(pend & mask_q));

  always_comb begin
    RD = '0;
    case (IDX)
      IDX_STATUS: begin
        RD[0]       = ie_q;
        RD[8 +: NP] = mask_q;
      end
      IDX_PENDING: RD[NP-1:0]    = pend;
      IDX_MODE:    RD[N_IRQ-1:0] = mode_q;
      IDX_COUNT:   RD[CW-1:0]    = count_q;
      default: begin
        for (int k = 0; k < N_TMR; k++) begin
          if (IDX == 5'(4 + 3*k)) RD[CW-1:0] = cmp_all[k*CW +: CW];
          if (IDX == 5'(5 + 3*k)) RD[CW-1:0] = per_all[k*CW +: CW];
          if (IDX == 5'(6 + 3*k)) RD[1:0]    = ctrl_all[2*k +: 2];
        end
      end
    endcase
  end

endmodule
`default_nettype wire
